// File: rtl/roulette_round_ctrl_if.sv
// Spin request/acknowledge link between the round sequencer (master) and
// the random-number generator (slave).
interface roulette_round_ctrl_if;
    logic       spin_req;
    logic       spin_ack;
    logic [4:0] spin_num;

    modport master (output spin_req, input spin_ack, input spin_num);
    modport slave  (input spin_req, output spin_ack, output spin_num);
endinterface

// File: rtl/roulette_round_ctrl.sv
// Even/odd roulette round sequencer: start-key edge detect, guess latch, spin
// handshake, scoring and LED pattern. Optional blinking under ROULETTE_LED_FLASH_EN.
module roulette_round_ctrl #(
    parameter logic [4:0] START_BAL = 5'd10,
    parameter logic [4:0] WIN_BAL   = 5'd20,
    parameter logic [4:0] WIN_AMT   = 5'd2,
    parameter logic [4:0] LOSE_AMT  = 5'd1,
    parameter int         FLASH_W   = 24
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start_key_i,
    input  logic                         player_guess_i,
    roulette_round_ctrl_if.master        spin,
    output logic [4:0]                   balance_o,
    output logic                         round_win_o,
    output logic                         round_lose_o,
    output logic                         game_over_o,
    output logic [2:0]                   state_out_o,
    output logic [4:0]                   fsm_out_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        SPIN  = 3'd2,
        EVAL  = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic       key_q;
    logic       guess_q;
    logic       parity_q;
    logic [4:0] balance_q, balance_d;
    logic       win_q, win_d;
    logic       lose_q, lose_d;
    logic       press;
    logic       correct;
    logic [5:0] sum6;
    logic [4:0] winBal;
    logic       flashPhase;

    assign press   = start_key_i & ~key_q;
    // Guess 1 means even, so a correct guess has spun LSB equal to ~guess.
    assign correct = (parity_q == ~guess_q);
    assign sum6    = {1'b0, balance_q} + {1'b0, WIN_AMT};
    assign winBal  = (sum6 > 6'd31) ? 5'd31 : sum6[4:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_q     <= 1'b0;
            guess_q   <= 1'b0;
            parity_q  <= 1'b0;
            balance_q <= START_BAL;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            key_q     <= start_key_i;
            balance_q <= balance_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            if (state_q == READY && press) begin
                guess_q <= player_guess_i;
            end
            if (state_q == SPIN && spin.spin_ack) begin
                parity_q <= spin.spin_num[0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        win_d     = 1'b0;
        lose_d    = 1'b0;
        case (state_q)
            IDLE: begin
                balance_d = START_BAL;
                state_d   = READY;
            end
            READY: begin
                if (press) state_d = SPIN;
            end
            SPIN: begin
                if (spin.spin_ack) state_d = EVAL;
            end
            EVAL: begin
                if (correct) begin
                    balance_d = winBal;
                    win_d     = 1'b1;
                    state_d   = (winBal > WIN_BAL) ? WIN : READY;
                end else begin
                    lose_d = 1'b1;
                    if (balance_q <= LOSE_AMT) begin
                        balance_d = 5'd0;
                        state_d   = LOSE;
                    end else begin
                        balance_d = balance_q - LOSE_AMT;
                        state_d   = READY;
                    end
                end
            end
            WIN, LOSE: begin
                if (press) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ROULETTE_LED_FLASH_EN
    logic [FLASH_W-1:0] flashCnt_q;
    logic               flash_q;
    logic               endNow, endNext;

    assign endNow  = (state_q == WIN) || (state_q == LOSE);
    assign endNext = (state_d == WIN) || (state_d == LOSE);

    // Restart lit on every entry so the end pattern is visible immediately.
    always_ff @(posedge clock) begin
        if (reset) begin
            flashCnt_q <= '0;
            flash_q    <= 1'b1;
        end else if (endNext && !endNow) begin
            flashCnt_q <= '0;
            flash_q    <= 1'b1;
        end else if (endNow) begin
            flashCnt_q <= flashCnt_q + 1'b1;
            if (&flashCnt_q) flash_q <= ~flash_q;
        end
    end

    assign flashPhase = flash_q;
`else
    assign flashPhase = (FLASH_W > 0);
`endif

    // Request is gated by reset so an outstanding spin is withdrawn at once.
    always_comb begin
        spin.spin_req = 1'b0;
        game_over_o   = 1'b0;
        fsm_out_o     = 5'b00000;
        case (state_q)
            SPIN: begin
                spin.spin_req = ~reset;
                fsm_out_o     = 5'b00001;
            end
            EVAL: fsm_out_o = 5'b00010;
            WIN: begin
                game_over_o = 1'b1;
                fsm_out_o   = 5'b11111 & {5{flashPhase}};
            end
            LOSE: begin
                game_over_o = 1'b1;
                fsm_out_o   = 5'b10101 & {5{flashPhase}};
            end
            default: ;
        endcase
    end

    assign balance_o    = balance_q;
    assign round_win_o  = win_q;
    assign round_lose_o = lose_q;
    assign state_out_o  = state_q;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// Directed self-checking bench for roulette_round_ctrl; honours ROULETTE_LED_FLASH_EN
// by expecting a blinking end pattern with FLASH_W=2.
module tb_roulette_round_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       startKey;
    logic       playerGuess;
    logic [4:0] balance;
    logic       roundWin;
    logic       roundLose;
    logic       gameOver;
    logic [2:0] stateOut;
    logic [4:0] fsmOut;
    int         checks   = 0;
    int         failures = 0;

    roulette_round_ctrl_if spinIf ();

    roulette_round_ctrl #(.FLASH_W(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_key_i    (startKey),
        .player_guess_i (playerGuess),
        .spin           (spinIf),
        .balance_o      (balance),
        .round_win_o    (roundWin),
        .round_lose_o   (roundLose),
        .game_over_o    (gameOver),
        .state_out_o    (stateOut),
        .fsm_out_o      (fsmOut)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One round: press, optional ack stall with key chatter, ack, EVAL, then the scoring edge.
    task automatic applyStimulus(input logic guess, input logic [4:0] num, input int delay);
        playerGuess = guess;
        startKey    = 1'b1;
        tick();
        startKey = 1'b0;
        checkOutput("spinReqOnPress", {31'd0, spinIf.spin_req}, 32'd1);
        checkOutput("stateSpin", {29'd0, stateOut}, 32'd2);
        for (int i = 0; i < delay; i++) begin
            startKey = ~startKey;
            tick();
            checkOutput("spinReqHeld", {31'd0, spinIf.spin_req}, 32'd1);
            checkOutput("stateStall", {29'd0, stateOut}, 32'd2);
        end
        startKey        = 1'b0;
        spinIf.spin_ack = 1'b1;
        spinIf.spin_num = num;
        tick();
        spinIf.spin_ack = 1'b0;
        spinIf.spin_num = 5'd0;
        checkOutput("stateEval", {29'd0, stateOut}, 32'd3);
        checkOutput("fsmEval", {27'd0, fsmOut}, 32'h02);
        checkOutput("noReqEval", {31'd0, spinIf.spin_req}, 32'd0);
        tick();
    endtask

    initial begin
        logic [4:0] expFsm;

        reset           = 1'b1;
        startKey        = 1'b0;
        playerGuess     = 1'b0;
        spinIf.spin_ack = 1'b0;
        spinIf.spin_num = 5'd0;
        tick();
        tick();
        checkOutput("rstState", {29'd0, stateOut}, 32'd0);
        checkOutput("rstBalance", {27'd0, balance}, 32'd10);
        checkOutput("rstSpinReq", {31'd0, spinIf.spin_req}, 32'd0);
        checkOutput("rstGameOver", {31'd0, gameOver}, 32'd0);
        checkOutput("rstFsm", {27'd0, fsmOut}, 32'd0);
        checkOutput("rstWin", {31'd0, roundWin}, 32'd0);
        checkOutput("rstLose", {31'd0, roundLose}, 32'd0);

        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("idleState", {29'd0, stateOut}, 32'd1);
        checkOutput("idleBalance", {27'd0, balance}, 32'd10);
        checkOutput("idleSpinReq", {31'd0, spinIf.spin_req}, 32'd0);
        checkOutput("idleFsm", {27'd0, fsmOut}, 32'd0);

        $display("[TB] single win round");
        applyStimulus(1'b1, 5'd4, 0);
        checkOutput("win1Pulse", {31'd0, roundWin}, 32'd1);
        checkOutput("win1NoLose", {31'd0, roundLose}, 32'd0);
        checkOutput("win1Balance", {27'd0, balance}, 32'd12);
        checkOutput("win1State", {29'd0, stateOut}, 32'd1);
        tick();
        checkOutput("win1PulseOnce", {31'd0, roundWin}, 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst2Balance", {27'd0, balance}, 32'd10);

        $display("[TB] losing streak");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 5'd4, 0);
            checkOutput("losePulse", {31'd0, roundLose}, 32'd1);
            checkOutput("loseNoWin", {31'd0, roundWin}, 32'd0);
            checkOutput("loseBalance", {27'd0, balance}, 32'(10 - i));
            checkOutput("loseState", {29'd0, stateOut}, (i == 10) ? 32'd5 : 32'd1);
        end
        checkOutput("loseGameOver", {31'd0, gameOver}, 32'd1);
        checkOutput("loseFsm", {27'd0, fsmOut}, 32'h15);
        tick();
        tick();
        tick();
        checkOutput("loseHoldBal", {27'd0, balance}, 32'd0);
        checkOutput("loseHoldState", {29'd0, stateOut}, 32'd5);
        startKey = 1'b1;
        tick();
        startKey = 1'b0;
        checkOutput("loseToIdle", {29'd0, stateOut}, 32'd0);
        tick();
        checkOutput("newGameState", {29'd0, stateOut}, 32'd1);
        checkOutput("newGameBal", {27'd0, balance}, 32'd10);

        $display("[TB] winning streak");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 5'd6, 0);
            checkOutput("streakPulse", {31'd0, roundWin}, 32'd1);
            checkOutput("streakBalance", {27'd0, balance}, 32'(10 + 2 * i));
            checkOutput("streakState", {29'd0, stateOut}, (i == 6) ? 32'd4 : 32'd1);
        end
        checkOutput("winGameOver", {31'd0, gameOver}, 32'd1);
        for (int k = 0; k < 8; k++) begin
`ifdef ROULETTE_LED_FLASH_EN
            expFsm = (k < 4) ? 5'b11111 : 5'b00000;
`else
            expFsm = 5'b11111;
`endif
            checkOutput("winFsm", {27'd0, fsmOut}, {27'd0, expFsm});
            tick();
        end
        startKey = 1'b1;
        tick();
        startKey = 1'b0;
        checkOutput("winToIdle", {29'd0, stateOut}, 32'd0);
        checkOutput("winIdleBal", {27'd0, balance}, 32'd22);
        tick();
        checkOutput("winNewState", {29'd0, stateOut}, 32'd1);
        checkOutput("winNewBal", {27'd0, balance}, 32'd10);

        $display("[TB] stalled generator");
        applyStimulus(1'b1, 5'd7, 7);
        checkOutput("stallLose", {31'd0, roundLose}, 32'd1);
        checkOutput("stallNoWin", {31'd0, roundWin}, 32'd0);
        checkOutput("stallBalance", {27'd0, balance}, 32'd9);
        checkOutput("stallState", {29'd0, stateOut}, 32'd1);
        tick();
        checkOutput("stallOnce", {31'd0, roundLose}, 32'd0);
        checkOutput("stallBalHold", {27'd0, balance}, 32'd9);

        $display("[TB] reset during spin");
        playerGuess = 1'b1;
        startKey    = 1'b1;
        tick();
        startKey = 1'b0;
        checkOutput("midSpinState", {29'd0, stateOut}, 32'd2);
        reset           = 1'b1;
        spinIf.spin_ack = 1'b1;
        spinIf.spin_num = 5'd4;
        #1;
        checkOutput("rstReqDrop", {31'd0, spinIf.spin_req}, 32'd0);
        tick();
        checkOutput("rstSpinIdle", {29'd0, stateOut}, 32'd0);
        checkOutput("rstSpinReq", {31'd0, spinIf.spin_req}, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("lateAckState", {29'd0, stateOut}, 32'd1);
        checkOutput("lateAckBal", {27'd0, balance}, 32'd10);
        tick();
        checkOutput("lateAckReady", {29'd0, stateOut}, 32'd1);
        checkOutput("lateAckNoWin", {31'd0, roundWin}, 32'd0);
        checkOutput("lateAckNoLose", {31'd0, roundLose}, 32'd0);
        spinIf.spin_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/roulette_round_ctrl.md
# roulette_round_ctrl

Round sequencer for the even/odd roulette game. Edge-detects the start key, latches the player's guess, requests a spin from the random-number generator over a req/ack handshake, and scores the result against the player balance. Drives win/lose end states and the LED pattern. Sits between the board keys/switches, the random generator and the hex/LED display logic.

## Interface
- START_BAL, 10: balance loaded at new game (5-bit).
- WIN_BAL, 20: game won when balance after a win exceeds this value.
- WIN_AMT, 2: credit per correct guess.
- LOSE_AMT, 1: debit per wrong guess.
- FLASH_W, 24: width of LED flash divider counter.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_key  in  1  synchronous level, high while the key is pressed; only rising edges act.
- player_guess  in  1  1 = even, 0 = odd.
- spin_req  out  1  spin request to the random generator.
- spin_ack  in  1  generator acknowledge; spin_num valid in the same cycle.
- spin_num  in  5  spun number.
- balance  out  5  current player balance.
- round_win  out  1  one-cycle pulse on a correct guess.
- round_lose  out  1  one-cycle pulse on a wrong guess.
- game_over  out  1  high in WIN or LOSE.
- state_out  out  3  state encoding, for debug/hex display.
- fsm_out  out  5  LED pattern.

## Operation
- States and encodings: IDLE=0, READY=1, SPIN=2, EVAL=3, WIN=4, LOSE=5. Codes 6 and 7 go to IDLE on the next cycle.
- Press edge: start_key high this cycle and low last cycle. A one-bit history register is cleared by reset.
- IDLE: load balance=START_BAL and go to READY next cycle. No pulses.
- READY: on a press edge, latch player_guess and go to SPIN.
- SPIN: spin_req is high for every SPIN cycle.
  - When spin_req and spin_ack are both high, latch spin_num and go to EVAL.
  - spin_ack is ignored outside SPIN.
- EVAL (one cycle): correct when spin_num[0] equals the inverse of the latched guess (even ↔ 1).
  - Correct: new balance = min(balance+WIN_AMT, 31), computed 6-bit. Pulse round_win. If new balance > WIN_BAL go to WIN, else READY.
  - Wrong: if balance <= LOSE_AMT, new balance = 0 and go to LOSE. Otherwise balance-LOSE_AMT and go to READY. Pulse round_lose.
- WIN/LOSE: balance holds and game_over=1. A press edge goes to IDLE, which starts a new game.
- Press edges in SPIN or EVAL are ignored; nothing is queued.
- fsm_out by state:
  - IDLE/READY: 00000.
  - SPIN: 00001.
  - EVAL: 00010.
  - WIN: 11111 with flash gating.
  - LOSE: 10101 with flash gating.
- Reset mid-operation (any state, including SPIN with the request outstanding): go to IDLE next edge. spin_req drops immediately; a late spin_ack is ignored.

## Timing
- Reset values:
  - Registered: state=IDLE, balance=START_BAL, round_win=0, round_lose=0, flash counter=0, flash phase=1, edge history=0.
  - Derived from state: spin_req=0, game_over=0, fsm_out=00000, state_out=0.
- spin_req, game_over, state_out and fsm_out are combinational from state and flash phase.
- Latencies:
  - Press edge at cycle N: state=SPIN and spin_req=1 at N+1.
  - Ack at cycle M: EVAL at M+1.
  - Updated balance, round_win/round_lose pulse and next state all at M+2.
- Minimum round is 3 cycles with same-cycle ack (ack seen at N+1). The generator may stall indefinitely; there is no timeout.
- Flash counter clears on entry to WIN/LOSE. Flash phase toggles each time the counter wraps at 2^FLASH_W.

## Configuration
- ROULETTE_LED_FLASH_EN defined: WIN/LOSE patterns are ANDed with flash phase, so they blink with period 2^(FLASH_W+1) cycles and are lit first on entry.
- Not defined: no flash counter is built and WIN/LOSE patterns are steady.

## Test plan
- Reset, hold idle 5 cycles -> balance=10, state_out=1, spin_req=0, fsm_out=00000.
- Guess even, press, ack with spin_num=4 same cycle -> round_win pulse at press+3, balance=12, state READY.
- Guess odd, spin_num=4, repeated from balance 10 -> balance 9,8,…,1, then 0, round_lose each round, then LOSE with game_over=1 and fsm_out pattern 10101.
- Six consecutive wins from 10 -> balance 12…22 and WIN at 22 (>20). A press edge then gives IDLE, then READY with balance=10.
- Delay ack 7 cycles: spin_req held 7+ cycles, extra presses ignored, then exactly one scoring pulse. Assert reset during SPIN -> IDLE next cycle, spin_req=0, late ack causes no score.
- With FLASH_W=2 and macro defined: WIN fsm_out alternates 11111/00000 every 4 cycles. With macro undefined: steady 11111.
